// File: rtl/relu_arbiter_pkg.sv
// Shared types and constants for the round-robin ReLU scheduler.
package relu_arbiter_pkg;

    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest positive value of a dw-bit signed result: {0, all ones}.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input int unsigned dw);
        return (SAT_MAX_W'(1) << (dw - 1)) - SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/relu_arbiter_if.sv
// Request/grant and result-stream bundle between the neuron accumulators, the scheduler and downstream.
interface relu_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LAYER_SIZE = 30
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned IDX_W = $clog2(LAYER_SIZE + 1);

    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ*2*DATA_WIDTH-1:0] sum;
    logic [NUM_REQ-1:0]              gnt;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [ID_W-1:0]                 out_id;
    logic [IDX_W-1:0]                out_idx;

    modport slave (
        input  req, sum, out_ready,
        output gnt, out_valid, out_data, out_id, out_idx
    );

    modport master (
        output req, sum, out_ready,
        input  gnt, out_valid, out_data, out_id, out_idx
    );

endinterface

// File: rtl/relu_arbiter_relu_sat.sv
// Saturating ReLU: clamps negatives to zero, saturates values that overflow the
// integer field, otherwise takes the fixed-point slice below the weight integer bits.
module relu_sat
    import relu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned WEIGHT_INT_WIDTH = 4
) (
    input  logic [2*DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0]   y_c
);

    localparam int unsigned XW        = 2 * DATA_WIDTH;
    localparam int unsigned HI_W      = WEIGHT_INT_WIDTH + 1;
    localparam int unsigned SLICE_MSB = XW - 1 - WEIGHT_INT_WIDTH;
    localparam logic [DATA_WIDTH-1:0] SAT = DATA_WIDTH'(sat_value(DATA_WIDTH));

    always_comb begin
        y_c = '0;
        if (x[XW-1]) begin
            y_c = '0;
        end else if (|x[XW-1 -: HI_W]) begin
            y_c = SAT;
        end else begin
            y_c = x[SLICE_MSB -: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/relu_arbiter.sv
// Layer scheduler: round-robin grants neuron sums into one ReLU unit and streams
// tagged results over valid/ready, pulsing done after the last result of a layer.
module relu_arbiter
    import relu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned WEIGHT_INT_WIDTH = 4,
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned LAYER_SIZE       = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    relu_arbiter_if.slave bus
);

    localparam int unsigned XW    = 2 * DATA_WIDTH;
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned IDX_W = $clog2(LAYER_SIZE + 1);

    state_t                state;
    state_t                state_next;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       rr_idx;
    logic [ID_W-1:0]       win_id;
    logic                  found;
    logic [IDX_W-1:0]      issued;
    logic                  issue;
    logic                  hs;
    logic                  last_hs;
    logic [NUM_REQ-1:0]    gnt_vec;
    logic [XW-1:0]         win_sum;
    logic [DATA_WIDTH-1:0] act;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        rr_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_idx = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && bus.req[rr_idx]) begin
                found  = 1'b1;
                win_id = rr_idx;
            end
        end
    end

    assign hs      = bus.out_valid && bus.out_ready;
    assign last_hs = hs && (bus.out_idx == IDX_W'(LAYER_SIZE - 1));
    assign issue   = (state == RUN) && (issued < IDX_W'(LAYER_SIZE)) && found
                     && (!bus.out_valid || bus.out_ready);
    assign win_sum = bus.sum[32'(win_id) * XW +: XW];

    always_comb begin
        gnt_vec = '0;
        if (issue) begin
            gnt_vec[win_id] = 1'b1;
        end
    end

    assign bus.gnt = gnt_vec;

    relu_sat #(
        .DATA_WIDTH       (DATA_WIDTH),
        .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH)
    ) u_relu_sat (
        .x   (win_sum),
        .y_c (act)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_hs) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered copies of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    // Result register, priority pointer and per-layer issue count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            issued        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_id    <= '0;
            bus.out_idx   <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                issued <= '0;
            end else if (issue) begin
                issued <= issued + IDX_W'(1);
            end

            if (issue) begin
                ptr           <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
                bus.out_valid <= 1'b1;
                bus.out_data  <= act;
                bus.out_id    <= win_id;
                bus.out_idx   <= issued;
            end else if (hs) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule
